fp_seq_subtractor: RTL and testbench
====================================

FP_SEQ_SUBTRACTOR -- requirements
Module: fp_seq_subtractor

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to compute x - y; sampled only in IDLE.
REQ-004 SHALL have port x, input, 32, IEEE-754 single minuend.
REQ-005 SHALL have port y, input, 32, IEEE-754 single subtrahend.
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-008 SHALL have port result, output, 32, x - y, held stable from done until next accepted start.
REQ-009 SHALL have port overflow_flag, output, 1, set when a finite difference rounds to infinity; held with result.

Function
REQ-010 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, ROUND, DONE; any unused encoding SHALL go to IDLE.
REQ-011 SHALL, in IDLE with start=1, register x and y with y sign inverted, then go to ALIGN; start in other states SHALL be ignored.
REQ-012 SHALL detect specials at capture and go directly to DONE: NaN operand -> 0x7FC00000; +inf - +inf or -inf - -inf -> 0x7FC00000; single infinity -> that signed infinity; x zero -> -y; y zero -> x.
REQ-013 SHALL, in ALIGN, shift the smaller-exponent 24-bit significand (with hidden bit) right one bit per cycle, OR-ing shifted-out bits into a sticky bit, until exponents match or 26 shifts are done.
REQ-014 SHALL, in ADD, add or subtract significands in one cycle at 27 bits (guard, round, sticky); on subtraction the larger magnitude SHALL be minuend and its sign the result sign.
REQ-015 SHALL, in NORM, handle carry-out by one right shift with exponent +1, otherwise left-shift one bit per cycle with exponent -1 until hidden bit is 1 or exponent reaches minimum.
REQ-016 SHALL round to nearest, ties to even, in ROUND; a rounding carry SHALL renormalise in the same cycle.
REQ-017 SHALL return +0 (0x00000000) for an exact-zero difference of finite operands.
REQ-018 SHALL saturate exponent >= 255 to signed infinity and set overflow_flag.
REQ-019 SHALL assert done exactly one cycle in DONE, then return to IDLE; start in that IDLE cycle SHALL be accepted.
REQ-020 SHALL complete a special-case operation with done high 2 cycles after the start sampling edge, and any operation within 60 cycles.
REQ-021 SHALL keep overflow_flag low for all special-case results.

Reset
REQ-022 SHALL, on rst=1 at a rising edge, enter IDLE and drive busy=0, done=0, result=0x00000000, overflow_flag=0.
REQ-023 SHALL abort an in-flight operation on reset mid-operation with no done pulse; rst has priority over start.

Configuration
REQ-024 SHALL use macro FP_SUB_SUBNORMAL_EN to select subnormal support.
REQ-025 SHALL, with FP_SUB_SUBNORMAL_EN defined, treat exponent-0 inputs as hidden bit 0, exponent 1, and emit subnormal results when normalisation stops at minimum exponent.
REQ-026 SHALL, without FP_SUB_SUBNORMAL_EN, flush subnormal inputs to signed zero before REQ-012 and flush subnormal results to +0.

Verification
REQ-027 SHALL cover x=0x3F800000, y=0x3F800000 -> result 0x00000000, overflow_flag 0.
REQ-028 SHALL cover x=0x3FC00000, y=0x3F000000 -> result 0x3F800000; x=0x3F000000, y=0x3F800000 -> 0xBF000000.
REQ-029 SHALL cover x=0x7F800000, y=0x7F800000 -> 0x7FC00000 with done 2 cycles after start.
REQ-030 SHALL cover x=0x7F7FFFFF, y=0xFF7FFFFF -> 0x7F800000, overflow_flag 1.
REQ-031 SHALL cover x=0x00000002, y=0x00000001 -> 0x00000001 with FP_SUB_SUBNORMAL_EN, 0x00000000 without.
REQ-032 SHALL cover rst pulsed during NORM of 0x3F800001 - 0x3F800000 -> no done, busy 0 and result 0x00000000 next cycle; start re-issued mid-operation is ignored.

Source files
------------

// File: rtl/fp_seq_subtractor.sv
// rtl/fp_seq_subtractor.sv - multi-cycle IEEE-754 single-precision subtractor (x - y)
// Optional subnormal support: define FP_SUB_SUBNORMAL_EN.
module fp_seq_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow_flag
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [9:0]  EXP_MIN   = 10'd1;
    localparam logic [4:0]  MAX_SHIFT = 5'd26;

    state_t state, state_next;

    // operand registers: 24-bit significand followed by guard, round, sticky
    logic        sign_a, sign_b;
    logic [9:0]  exp_a, exp_b;
    logic [26:0] man_a, man_b;
    logic [4:0]  shift_cnt;

    // working result: bit 27 carry, bit 26 hidden, bits 2:0 guard/round/sticky
    logic        sign_r;
    logic [9:0]  exp_r;
    logic [27:0] sum;

    logic [31:0] pend_result;
    logic        pend_ovf;

    logic [31:0] op_a, op_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        special;
    logic [31:0] special_result;
    logic [9:0]  cap_exp_a, cap_exp_b;
    logic [23:0] cap_sig_a, cap_sig_b;

    logic        align_done, norm_done, a_bigger;
    logic [27:0] add_sum;

    logic        round_up, rnd_ovf;
    logic [24:0] rnd_sig;
    logic [23:0] fin_sig;
    logic [9:0]  fin_exp;
    logic [31:0] rnd_result;

    assign busy = (state != IDLE);

    // operands as a = x and b = -y; subnormals flush to signed zero when unsupported
    always_comb begin
        op_a = x;
        op_b = {~y[31], y[30:0]};
`ifndef FP_SUB_SUBNORMAL_EN
        if (op_a[30:23] == 8'd0) op_a = {op_a[31], 31'd0};
        if (op_b[30:23] == 8'd0) op_b = {op_b[31], 31'd0};
`endif
    end

    assign a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
    assign b_nan  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
    assign a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
    assign b_inf  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
    assign a_zero = (op_a[30:0] == 31'd0);
    assign b_zero = (op_b[30:0] == 31'd0);

    // exponent-0 operands carry hidden bit 0 at exponent 1
    assign cap_exp_a = (op_a[30:23] == 8'd0) ? EXP_MIN : {2'b00, op_a[30:23]};
    assign cap_exp_b = (op_b[30:23] == 8'd0) ? EXP_MIN : {2'b00, op_b[30:23]};
    assign cap_sig_a = {(op_a[30:23] != 8'd0), op_a[22:0]};
    assign cap_sig_b = {(op_b[30:23] != 8'd0), op_b[22:0]};

    // special operands bypass the datapath; an exact zero difference of two zeros is +0
    always_comb begin
        special        = 1'b1;
        special_result = 32'd0;
        if (a_nan || b_nan)          special_result = QNAN;
        else if (a_inf && b_inf)     special_result = (op_a[31] == op_b[31]) ? op_a : QNAN;
        else if (a_inf)              special_result = op_a;
        else if (b_inf)              special_result = op_b;
        else if (a_zero && b_zero)   special_result = 32'd0;
        else if (a_zero)             special_result = op_b;
        else if (b_zero)             special_result = op_a;
        else                         special        = 1'b0;
    end

    assign align_done = (exp_a == exp_b) || (shift_cnt == MAX_SHIFT);
    assign norm_done  = sum[27] || sum[26] || (exp_r == EXP_MIN) || (sum == 28'd0);
    assign a_bigger   = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));

    // signed-magnitude add: larger magnitude is always the minuend
    always_comb begin
        add_sum = 28'd0;
        if (sign_a == sign_b)  add_sum = {1'b0, man_a} + {1'b0, man_b};
        else if (a_bigger)     add_sum = {1'b0, man_a - man_b};
        else                   add_sum = {1'b0, man_b - man_a};
    end

    // round to nearest even, renormalise a rounding carry, then pack
    always_comb begin
        round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd_sig  = {1'b0, sum[26:3]} + {24'd0, round_up};
        if (rnd_sig[24]) begin
            fin_sig = rnd_sig[24:1];
            fin_exp = exp_r + 10'd1;
        end else begin
            fin_sig = rnd_sig[23:0];
            fin_exp = exp_r;
        end
        rnd_ovf = 1'b0;
        if (sum == 28'd0) begin
            rnd_result = 32'd0;
        end else if (fin_exp >= 10'd255) begin
            rnd_result = {sign_r, 8'hFF, 23'd0};
            rnd_ovf    = 1'b1;
        end else if (!fin_sig[23]) begin
`ifdef FP_SUB_SUBNORMAL_EN
            rnd_result = {sign_r, 8'd0, fin_sig[22:0]};
`else
            rnd_result = 32'd0;
`endif
        end else begin
            rnd_result = {sign_r, fin_exp[7:0], fin_sig[22:0]};
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = special ? DONE : ALIGN;
            ALIGN:   if (align_done) state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    if (norm_done) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            exp_a         <= 10'd0;
            exp_b         <= 10'd0;
            man_a         <= 27'd0;
            man_b         <= 27'd0;
            shift_cnt     <= 5'd0;
            sign_r        <= 1'b0;
            exp_r         <= 10'd0;
            sum           <= 28'd0;
            pend_result   <= 32'd0;
            pend_ovf      <= 1'b0;
            done          <= 1'b0;
            result        <= 32'd0;
            overflow_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a      <= op_a[31];
                        sign_b      <= op_b[31];
                        exp_a       <= cap_exp_a;
                        exp_b       <= cap_exp_b;
                        man_a       <= {cap_sig_a, 3'b000};
                        man_b       <= {cap_sig_b, 3'b000};
                        shift_cnt   <= 5'd0;
                        pend_result <= special_result;
                        pend_ovf    <= 1'b0;
                    end
                end
                ALIGN: begin
                    if (!align_done) begin
                        if (exp_a < exp_b) begin
                            man_a <= {1'b0, man_a[26:2], man_a[1] | man_a[0]};
                            exp_a <= exp_a + 10'd1;
                        end else begin
                            man_b <= {1'b0, man_b[26:2], man_b[1] | man_b[0]};
                            exp_b <= exp_b + 10'd1;
                        end
                        shift_cnt <= shift_cnt + 5'd1;
                    end
                end
                ADD: begin
                    sum    <= add_sum;
                    exp_r  <= a_bigger ? exp_a : exp_b;
                    sign_r <= a_bigger ? sign_a : sign_b;
                end
                NORM: begin
                    if (sum[27]) begin
                        sum   <= {1'b0, sum[27:2], sum[1] | sum[0]};
                        exp_r <= exp_r + 10'd1;
                    end else if (!norm_done) begin
                        sum   <= sum << 1;
                        exp_r <= exp_r - 10'd1;
                    end
                end
                ROUND: begin
                    pend_result <= rnd_result;
                    pend_ovf    <= rnd_ovf;
                end
                DONE: begin
                    done          <= 1'b1;
                    result        <= pend_result;
                    overflow_flag <= pend_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_seq_subtractor.sv
// tb/tb_fp_seq_subtractor.sv - self-checking bench for fp_seq_subtractor
module tb_fp_seq_subtractor;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow_flag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        ovf;
        logic        spec;
    } vec_t;

    vec_t tbl [17];

    fp_seq_subtractor dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .x             (x),
        .y             (y),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_max(input string name, input int act, input int limit);
        tests++;
        if (act > limit) begin
            fails++;
            $display("FAIL %s: got %0d expected at most %0d", name, act, limit);
        end
    endtask

    // exact reference: operands as integers in units of 2^-149, then one rounding step
    function automatic void model(input logic [31:0] xi, input logic [31:0] yi,
                                  output logic [31:0] r, output logic ovf);
        logic [31:0]  a, b;
        logic [299:0] va, vb, d, tmp, rem, half, mask;
        logic         sd;
        logic [24:0]  m;
        int           ea, eb, p, sh, e;
        ovf = 1'b0;
        r   = 32'd0;
        a   = xi;
        b   = {~yi[31], yi[30:0]};
`ifndef FP_SUB_SUBNORMAL_EN
        if (a[30:23] == 8'd0) a = {a[31], 31'd0};
        if (b[30:23] == 8'd0) b = {b[31], 31'd0};
`endif
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) r = 32'h7FC00000;
        else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) r = (a[31] == b[31]) ? a : 32'h7FC00000;
        else if (a[30:23] == 8'hFF) r = a;
        else if (b[30:23] == 8'hFF) r = b;
        else if (a[30:0] == 0 && b[30:0] == 0) r = 32'd0;
        else if (a[30:0] == 0) r = b;
        else if (b[30:0] == 0) r = a;
        else begin
            ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
            eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
            va = '0;
            vb = '0;
            va[23:0] = {(a[30:23] != 0), a[22:0]};
            vb[23:0] = {(b[30:23] != 0), b[22:0]};
            va = va << (ea - 1);
            vb = vb << (eb - 1);
            if (a[31] == b[31]) begin d = va + vb; sd = a[31]; end
            else if (va >= vb)  begin d = va - vb; sd = a[31]; end
            else                begin d = vb - va; sd = b[31]; end
            if (d != 0) begin
                p = 0;
                for (int i = 0; i < 300; i++) if (d[i]) p = i;
                if (p < 23) begin
`ifdef FP_SUB_SUBNORMAL_EN
                    r = {sd, 8'd0, d[22:0]};
`else
                    r = 32'd0;
`endif
                end else begin
                    sh   = p - 23;
                    tmp  = d >> sh;
                    m    = tmp[24:0];
                    mask = {300{1'b1}} << sh;
                    rem  = d & ~mask;
                    half = (sh > 0) ? (300'd1 << (sh - 1)) : 300'd0;
                    if (sh > 0 && (rem > half || (rem == half && m[0]))) m = m + 25'd1;
                    e = p - 22;
                    if (m[24]) begin m = m >> 1; e++; end
                    if (e >= 255) begin
                        r   = {sd, 8'hFF, 23'd0};
                        ovf = 1'b1;
                    end else begin
                        r = {sd, e[7:0], m[22:0]};
                    end
                end
            end
        end
    endfunction

    // issue one operation at a negedge and wait (bounded) for done
    task automatic do_op(input logic [31:0] xi, input logic [31:0] yi,
                         output logic [31:0] r, output logic o, output int lat);
        x = xi;
        y = yi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        o = overflow_flag;
    endtask

    initial begin
        logic [31:0] r, er, xr, yr;
        logic        o, eo;
        int          lat, dn, dsel;

        tbl[0]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
        tbl[1]  = '{32'h3FC00000, 32'h3F000000, 32'h3F800000, 1'b0, 1'b0};
        tbl[2]  = '{32'h3F000000, 32'h3F800000, 32'hBF000000, 1'b0, 1'b0};
        tbl[3]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1};
        tbl[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0};
`ifdef FP_SUB_SUBNORMAL_EN
        tbl[5]  = '{32'h00000002, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
`else
        tbl[5]  = '{32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
`endif
        tbl[6]  = '{32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
        tbl[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1};
        tbl[8]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b1};
        tbl[9]  = '{32'h40400000, 32'h00000000, 32'h40400000, 1'b0, 1'b1};
        tbl[10] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b1};
        tbl[11] = '{32'h3F800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b1};
        tbl[12] = '{32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 1'b0};
        tbl[13] = '{32'h3F800000, 32'hB3800000, 32'h3F800000, 1'b0, 1'b0};
        tbl[14] = '{32'h3F800000, 32'hB3C00000, 32'h3F800001, 1'b0, 1'b0};
        tbl[15] = '{32'h4F000000, 32'h3F800000, 32'h4F000000, 1'b0, 1'b0};
        tbl[16] = '{32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        x = 32'd0;
        y = 32'd0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset overflow", {31'd0, overflow_flag}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // table vectors, issued back to back (each start lands in the previous done cycle)
        for (int i = 0; i < 17; i++) begin
            do_op(tbl[i].x, tbl[i].y, r, o, lat);
            check($sformatf("vec%0d result", i), r, tbl[i].res);
            check($sformatf("vec%0d overflow", i), {31'd0, o}, {31'd0, tbl[i].ovf});
            check($sformatf("vec%0d busy at done", i), {31'd0, busy}, 32'd0);
            if (tbl[i].spec) check($sformatf("vec%0d special latency", i), lat, 2);
            else             check_max($sformatf("vec%0d latency", i), lat, 60);
        end

        @(negedge clk);
        check("done pulse width", {31'd0, done}, 32'd0);
        check("result held", result, 32'h34000000);

        // start re-issued mid-operation is ignored
        x = 32'h3F800001;
        y = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy in flight", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        x = 32'h40000000;
        y = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("ignored start result", result, 32'h34000000);

        // reset during NORM aborts with no done, rst wins over start
        x = 32'h3F800001;
        y = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        x = 32'h40000000;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort overflow", {31'd0, overflow_flag}, 32'd0);
        dn = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("no done after abort", dn, 0);

        // randomized operands against the exact reference
        for (int n = 0; n < 400; n++) begin
            xr = $urandom;
            yr = $urandom;
            dsel = $urandom_range(0, 4);
            case (dsel)
                1: begin
                    dn = $urandom_range(0, 4) - 2;
                    yr[30:23] = xr[30:23] + dn[7:0];
                end
                2: yr = xr ^ ($urandom & 32'h000000FF);
                3: begin
                    dn = $urandom_range(0, 3);
                    xr[30:23] = dn[7:0];
                    dn = $urandom_range(0, 3);
                    yr[30:23] = dn[7:0];
                end
                4: begin
                    if ($urandom_range(0, 1) == 1) xr[30:23] = 8'hFF;
                    else                           yr[30:23] = 8'hFE;
                end
                default: ;
            endcase
            model(xr, yr, er, eo);
            do_op(xr, yr, r, o, lat);
            check($sformatf("rand %08h-%08h result", xr, yr), r, er);
            check($sformatf("rand %08h-%08h overflow", xr, yr), {31'd0, o}, {31'd0, eo});
            check_max($sformatf("rand %08h-%08h latency", xr, yr), lat, 60);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
